// File: rtl/riscv_bp_pkg.sv
// Shared types and helpers for the two-bit branch history table.
package riscv_bp_pkg;

  // Two-bit saturating direction counter; bit 1 is the predicted direction.
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  // Table controller: INIT sweeps every entry to CTR_INIT, RUN predicts and trains.
  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } bp_state_t;

  localparam ctr_t        CTR_INIT = WNT;
  localparam logic [31:0] PC_STEP  = 32'd4;

  // Saturating counter update: taken moves toward ST, not-taken toward SNT.
  function automatic ctr_t ctr_next(input ctr_t cur, input logic taken);
    logic [1:0] v;
    v = cur;
    if (taken) begin
      if (v != 2'b11) v = v + 2'd1;
    end else begin
      if (v != 2'b00) v = v - 2'd1;
    end
    return ctr_t'(v);
  endfunction

endpackage

// File: rtl/bht_ram.sv
// Counter storage: asynchronous read ports for fetch and resolve, one synchronous write port.
module bht_ram #(
  parameter int IndexBits = 6
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [IndexBits-1:0] waddr,
  input  logic [1:0]           wdata,
  input  logic [IndexBits-1:0] raddr_a,
  output logic [1:0]           rdata_a,
  input  logic [IndexBits-1:0] raddr_b,
  output logic [1:0]           rdata_b
);

  localparam int Depth = 1 << IndexBits;

  logic [1:0] mem [Depth];

  // Single write port; contents are defined by the INIT sweep, so no reset here.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/branch_predictor_unit.sv
// Two-bit BHT: fetch-time direction prediction, resolve-time mispredict/redirect and training.
//
// Handshake: there is no valid/ready pair on fetch; Ready=0 means the table is still being
// swept, predictions read 0 and any ResolveValid is ignored (no training, no counting,
// no Mispredict). Once Ready=1 every ResolveValid cycle is one resolved branch.
module branch_predictor_unit
  import riscv_bp_pkg::*;
#(
  parameter int IndexBits = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] FetchPC,
  output logic        PredictTaken,
  output logic        Ready,
  input  logic        ResolveValid,
  input  logic [31:0] ResolvePC,
  input  logic        ResolvePredTaken,
  input  logic        Muxselect,
  input  logic [31:0] BranchTarget,
  output logic        Mispredict,
  output logic [31:0] RedirectPC,
  output logic [31:0] BranchCount,
  output logic [31:0] MispredictCount,
  output bp_state_t   dbg_state
);

  bp_state_t            state;
  logic [IndexBits-1:0] init_index;
  logic [IndexBits-1:0] fetch_idx;
  logic [IndexBits-1:0] res_idx;
  logic [1:0]           fetch_ctr;
  logic [1:0]           res_ctr;
  logic                 train;
  logic                 we;
  logic [IndexBits-1:0] waddr;
  logic [1:0]           wdata;
  logic                 unused_pc_bits;

  assign fetch_idx      = FetchPC[IndexBits+1:2];
  assign res_idx        = ResolvePC[IndexBits+1:2];
  assign unused_pc_bits = ^{FetchPC[31:IndexBits+2], FetchPC[1:0],
                            ResolvePC[31:IndexBits+2], ResolvePC[1:0]};

  assign Ready     = (state == RUN);
  assign dbg_state = state;
  assign train     = Ready & ResolveValid;

  // INIT sweeps InitIndex through every entry once, then RUN until the next reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= INIT;
      init_index <= '0;
    end else if (state == INIT) begin
      init_index <= init_index + 1'b1;
      if (&init_index) state <= RUN;
    end
  end

  // Write port shared by the INIT sweep and training; reset discards any in-flight write.
  always_comb begin
    we    = 1'b0;
    waddr = init_index;
    wdata = CTR_INIT;
    if (!reset) begin
      if (state == INIT) begin
        we = 1'b1;
      end else if (train) begin
        we    = 1'b1;
        waddr = res_idx;
        wdata = ctr_next(ctr_t'(res_ctr), Muxselect);
      end
    end
  end

  bht_ram #(
    .IndexBits(IndexBits)
  ) u_bht_ram (
    .clk    (clk),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .raddr_a(fetch_idx),
    .rdata_a(fetch_ctr),
    .raddr_b(res_idx),
    .rdata_b(res_ctr)
  );

  // Prediction reads the stored value; a same-cycle update is not bypassed.
  assign PredictTaken = Ready & fetch_ctr[1];
  assign Mispredict   = train & (Muxselect != ResolvePredTaken);

  // Redirect address follows the actual outcome whenever a branch is presented.
  always_comb begin
    RedirectPC = 32'd0;
    if (ResolveValid) RedirectPC = Muxselect ? BranchTarget : (ResolvePC + PC_STEP);
  end

  // Performance counters, cleared by reset and wrapping naturally at 2**32.
  always_ff @(posedge clk) begin
    if (reset) begin
      BranchCount     <= 32'd0;
      MispredictCount <= 32'd0;
    end else begin
      if (train)      BranchCount     <= BranchCount + 32'd1;
      if (Mispredict) MispredictCount <= MispredictCount + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor_unit.sv
// Directed bench for branch_predictor_unit with a table-level reference model.
module tb_branch_predictor_unit;
  import riscv_bp_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic [31:0] FetchPC = 32'd0;
  logic        PredictTaken;
  logic        Ready;
  logic        ResolveValid = 1'b0;
  logic [31:0] ResolvePC = 32'd0;
  logic        ResolvePredTaken = 1'b0;
  logic        Muxselect = 1'b0;
  logic [31:0] BranchTarget = 32'd0;
  logic        Mispredict;
  logic [31:0] RedirectPC;
  logic [31:0] BranchCount;
  logic [31:0] MispredictCount;
  bp_state_t   dbg_state;

  branch_predictor_unit #(.IndexBits(6)) dut (
    .clk             (clk),
    .reset           (reset),
    .FetchPC         (FetchPC),
    .PredictTaken    (PredictTaken),
    .Ready           (Ready),
    .ResolveValid    (ResolveValid),
    .ResolvePC       (ResolvePC),
    .ResolvePredTaken(ResolvePredTaken),
    .Muxselect       (Muxselect),
    .BranchTarget    (BranchTarget),
    .Mispredict      (Mispredict),
    .RedirectPC      (RedirectPC),
    .BranchCount     (BranchCount),
    .MispredictCount (MispredictCount),
    .dbg_state       (dbg_state)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int pass_cnt  = 0;
  int total_cnt = 0;
  bit checking  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Table of integer counters 0..3, a countdown of sweep cycles left, and two tallies.
  int          m_ctr[64];
  int          init_left = 64;
  logic [31:0] m_bc = 32'd0;
  logic [31:0] m_mc = 32'd0;

  function automatic int idx_of(input logic [31:0] pc);
    return int'(pc[7:2]);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      init_left = 64;
      m_bc      = 32'd0;
      m_mc      = 32'd0;
    end else if (init_left > 0) begin
      init_left--;
      if (init_left == 0) foreach (m_ctr[i]) m_ctr[i] = 1;
    end else if (ResolveValid) begin
      m_bc++;
      if (Muxselect != ResolvePredTaken) m_mc++;
      if (Muxselect) m_ctr[idx_of(ResolvePC)] = (m_ctr[idx_of(ResolvePC)] == 3) ? 3 : m_ctr[idx_of(ResolvePC)] + 1;
      else           m_ctr[idx_of(ResolvePC)] = (m_ctr[idx_of(ResolvePC)] == 0) ? 0 : m_ctr[idx_of(ResolvePC)] - 1;
    end
  end

  // Every-cycle compare against the model, mid-cycle on the falling edge.
  always @(negedge clk) begin
    if (checking) begin
      logic        m_ready;
      logic        e_pred;
      logic        e_mis;
      logic [31:0] e_redir;
      m_ready = (init_left == 0);
      e_pred  = m_ready && (m_ctr[idx_of(FetchPC)] >= 2);
      e_mis   = m_ready && ResolveValid && (Muxselect != ResolvePredTaken);
      e_redir = !ResolveValid ? 32'd0 : (Muxselect ? BranchTarget : ResolvePC + 32'd4);
      chk("cyc_ready", {31'd0, Ready}, {31'd0, m_ready});
      chk("cyc_state", {31'd0, dbg_state == RUN}, {31'd0, m_ready});
      chk("cyc_pred", {31'd0, PredictTaken}, {31'd0, e_pred});
      chk("cyc_mispredict", {31'd0, Mispredict}, {31'd0, e_mis});
      chk("cyc_redirect", RedirectPC, e_redir);
      chk("cyc_branch_count", BranchCount, m_bc);
      chk("cyc_mispredict_count", MispredictCount, m_mc);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_res(input logic [31:0] pc, input logic pred, input logic mux,
                         input logic [31:0] tgt);
    ResolveValid     = 1'b1;
    ResolvePC        = pc;
    ResolvePredTaken = pred;
    Muxselect        = mux;
    BranchTarget     = tgt;
  endtask

  task automatic clr_res();
    ResolveValid = 1'b0;
    Muxselect    = 1'b0;
    BranchTarget = 32'd0;
  endtask

  // One resolve cycle, then the inputs are withdrawn.
  task automatic resolve(input logic [31:0] pc, input logic pred, input logic mux);
    set_res(pc, pred, mux, 32'h0000_1000);
    step();
    clr_res();
  endtask

  // Waits for Ready with a cycle budget and returns the edge count.
  task automatic wait_ready(output int n);
    n = 0;
    while (Ready !== 1'b1 && n < 200) begin
      FetchPC = 32'(n) << 2;
      step();
      n++;
    end
  endtask

  // ---------------- directed sequence ----------------
  logic t_pred[4] = '{1'b0, 1'b1, 1'b1, 1'b1};
  logic nt_pred[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
  logic t_after[4] = '{1'b1, 1'b1, 1'b1, 1'b1};
  logic nt_after[4] = '{1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    int n;
    reset = 1'b1;
    step();
    checking = 1'b1;
    step();
    step();
    chk("reset_ready", {31'd0, Ready}, 32'd0);
    chk("reset_redirect", RedirectPC, 32'd0);
    chk("reset_branch_count", BranchCount, 32'd0);
    chk("reset_mispredict_count", MispredictCount, 32'd0);
    reset = 1'b0;

    // Resolves during the sweep must be ignored entirely.
    set_res(32'h0000_0100, 1'b1, 1'b0, 32'd0);
    #1;
    chk("init_mispredict_suppressed", {31'd0, Mispredict}, 32'd0);
    wait_ready(n);
    clr_res();
    chk("init_ready_latency", 32'(n), 32'd64);
    chk("init_branch_count", BranchCount, 32'd0);

    // Saturation upward then downward on entry for 0x100.
    FetchPC = 32'h0000_0100;
    #1;
    chk("sat_initial_pred", {31'd0, PredictTaken}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      resolve(32'h0000_0100, t_pred[i], 1'b1);
      chk("sat_taken_pred", {31'd0, PredictTaken}, {31'd0, t_after[i]});
    end
    for (int i = 0; i < 4; i++) begin
      resolve(32'h0000_0100, nt_pred[i], 1'b0);
      chk("sat_not_taken_pred", {31'd0, PredictTaken}, {31'd0, nt_after[i]});
    end
    chk("sat_branch_count", BranchCount, 32'd8);
    chk("sat_mispredict_count", MispredictCount, 32'd3);

    // Not-taken mispredict at the top of the address space wraps the redirect.
    set_res(32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0000_5000);
    #1;
    chk("wrap_mispredict", {31'd0, Mispredict}, 32'd1);
    chk("wrap_redirect", RedirectPC, 32'h0000_0000);
    step();
    clr_res();
    chk("wrap_mispredict_count", MispredictCount, 32'd4);

    // Taken mispredict redirects to the computed target.
    set_res(32'h0000_0300, 1'b0, 1'b1, 32'h0000_2000);
    #1;
    chk("taken_mispredict", {31'd0, Mispredict}, 32'd1);
    chk("taken_redirect", RedirectPC, 32'h0000_2000);
    step();
    clr_res();
    chk("taken_mispredict_count", MispredictCount, 32'd5);

    // Correct prediction: no mispredict, redirect still reflects the outcome.
    set_res(32'h0000_0500, 1'b0, 1'b0, 32'h0000_7000);
    #1;
    chk("correct_no_mispredict", {31'd0, Mispredict}, 32'd0);
    chk("correct_redirect", RedirectPC, 32'h0000_0504);
    step();
    clr_res();

    // Fetch and resolve collide on 0x40: old value this cycle, new value next cycle.
    FetchPC = 32'h0000_0040;
    set_res(32'h0000_0040, 1'b0, 1'b1, 32'h0000_0080);
    #1;
    chk("collide_same_cycle", {31'd0, PredictTaken}, 32'd0);
    step();
    clr_res();
    chk("collide_next_cycle", {31'd0, PredictTaken}, 32'd1);
    chk("collide_branch_count", BranchCount, 32'd12);

    // Train 0x100 (currently SNT) up to ST, then reset mid-run with a resolve in flight.
    FetchPC = 32'h0000_0100;
    resolve(32'h0000_0100, 1'b0, 1'b1);
    resolve(32'h0000_0100, 1'b0, 1'b1);
    resolve(32'h0000_0100, 1'b1, 1'b1);
    chk("pre_reset_pred", {31'd0, PredictTaken}, 32'd1);
    set_res(32'h0000_0100, 1'b1, 1'b0, 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midreset_ready_dropped", {31'd0, Ready}, 32'd0);
    chk("midreset_mispredict_suppressed", {31'd0, Mispredict}, 32'd0);
    chk("midreset_branch_count", BranchCount, 32'd0);
    wait_ready(n);
    clr_res();
    chk("midreset_ready_latency", 32'(n), 32'd64);
    FetchPC = 32'h0000_0100;
    #1;
    chk("midreset_pred_weak_nt", {31'd0, PredictTaken}, 32'd0);
    chk("midreset_mispredict_count", MispredictCount, 32'd0);
    resolve(32'h0000_0100, 1'b0, 1'b1);
    chk("midreset_one_step_to_wt", {31'd0, PredictTaken}, 32'd1);
    chk("midreset_count_after", BranchCount, 32'd1);

    step();
    step();
    checking = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
